counter_bcd_countdown: RTL
==========================

Name: counter_bcd_countdown

Overview:
- BCD countdown timer, MM:SS, counting 59:59 down to 00:00.
- Complement of the up-counting BCD minute/second counters: loads a preset, decrements once per `tick` strobe, stops at 00:00 and flags completion.
- Drives four seven-segment digits through the existing `seven_segment` decoder. Also exposes raw BCD for debug.
- Sits between the 1 Hz tick generator and the display/alarm logic.

Parameters:
- DEFAULT_MIN, 8'h05, BCD minutes loaded on reset.
- DEFAULT_SEC, 8'h00, BCD seconds loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  load preset_min/preset_sec and return to IDLE.
- preset_min  input  8  BCD minutes: [7:4] tens, [3:0] ones.
- preset_sec  input  8  BCD seconds: [7:4] tens, [3:0] ones.
- start  input  1  start or resume counting.
- pause  input  1  suspend counting.
- tick  input  1  one-clk count enable (1 Hz strobe).
- s  output  16  BCD value: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- q  output  28  seven-segment: [6:0] sec ones, [13:7] sec tens, [20:14] min ones, [27:21] min tens.
- running  output  1  high while state is RUN.
- done  output  1  high while state is DONE.
- borrow_out  output  1  one-clk pulse when the count reaches 00:00.

Behaviour:
- Reset (reset==0, async):
  - s = {DEFAULT_MIN, DEFAULT_SEC}; state = IDLE.
  - running = 0, done = 0, borrow_out = 0.
- Register types:
  - s, state and borrow_out are registered.
  - q is combinational from s, via four `seven_segment` instances.
  - running and done decode state directly.
- Preset clamp, per digit on load:
  - ones digits > 9 become 9.
  - tens digits > 5 become 5.
  - Example: preset_min=8'h7C loads as 8'h59.
- Decrement, on tick in RUN:
  - sec ones: 0 wraps to 9 and borrows from sec tens.
  - sec tens: 0 wraps to 5 and borrows from min ones.
  - min ones: 0 wraps to 9 and borrows from min tens.
  - min tens never wraps, because the count stops at 0000.
  - s updates on the same edge that samples tick=1 (1-cycle latency).
- FSM (states IDLE, RUN, PAUSE, DONE). load has highest priority in every state: apply the clamped preset, go to IDLE, ignore tick that cycle.
  - IDLE:
    - start with s != 0000 goes to RUN.
    - start with s == 0000 is ignored; stay IDLE.
    - tick and pause are ignored.
  - RUN:
    - pause goes to PAUSE, with no decrement that cycle; pause beats both start and tick.
    - Otherwise tick decrements.
    - If s == 0001 and tick: s becomes 0000, go to DONE, borrow_out=1 for that one cycle.
  - PAUSE:
    - start goes to RUN; start beats pause.
    - A tick in the resume cycle is ignored; decrementing resumes on the next tick.
    - Otherwise hold s.
  - DONE:
    - Hold s=0000 and done=1.
    - start, pause and tick are ignored.
    - Only load or reset exits.
- borrow_out is never high outside the single RUN→DONE transition cycle.
- Reset mid-count immediately restores the defaults and clears all flags; there is no partial decrement.

Test Plan:
- Reset: reset=0 → s=16'h0500, IDLE, running=0, done=0, borrow_out=0; q equals the seven_segment codes of 0,0,5,0.
- Borrow chain: load 10:00, start, 1 tick → s=16'h0959 on that edge; next tick → 16'h0958.
- Terminal count: load 00:02, start, 2 ticks.
  - First tick → s=16'h0001.
  - Second tick → s=16'h0000, done=1, borrow_out=1 for exactly one clk.
  - Further ticks and start leave s=0000 with done=1.
- Pause/resume: load 00:10, start, 3 ticks, then pause with tick in the same cycle → s=16'h0007, running=0.
  - Ticks while paused leave s=16'h0007.
  - start with tick in the same cycle → s holds 16'h0007; next tick → 16'h0006.
- Clamp and priority:
  - load with preset_min=8'h7C, preset_sec=8'h6F → s=16'h5959.
  - In RUN, load with tick in the same cycle → s = the new preset, state IDLE.
  - In IDLE, start with s=0000 → stays IDLE.
- Async reset mid-run at 03:27 with no clk edge → s=16'h0500 and flags clear immediately.

Source files
------------

// File: rtl/counter_bcd_countdown.sv
// BCD MM:SS countdown timer with seven-segment outputs.
// Counts a clamped preset down to 00:00 on tick strobes, with start/pause/load
// control, a one-cycle borrow_out pulse on reaching zero, and a sticky done state.

// Seven-segment decoder, active-high segments {g,f,e,d,c,b,a}; non-BCD codes blank.
module seven_segment (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Map a BCD digit to its segment pattern.
  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

module counter_bcd_countdown #(
  parameter logic [7:0] DEFAULT_MIN = 8'h05,
  parameter logic [7:0] DEFAULT_SEC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  preset_min,
  input  logic [7:0]  preset_sec,
  input  logic        start,
  input  logic        pause,
  input  logic        tick,
  output logic [15:0] s,
  output logic [27:0] q,
  output logic        running,
  output logic        done,
  output logic        borrow_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] s_next;
  logic        borrow_next;

  // Limit a ones digit to 9.
  function automatic logic [3:0] clamp_ones(input logic [3:0] d);
    if (d > 4'd9) begin
      clamp_ones = 4'd9;
    end else begin
      clamp_ones = d;
    end
  endfunction

  // Limit a tens digit to 5.
  function automatic logic [3:0] clamp_tens(input logic [3:0] d);
    if (d > 4'd5) begin
      clamp_tens = 4'd5;
    end else begin
      clamp_tens = d;
    end
  endfunction

  // One-second BCD decrement with borrow ripple; minute tens saturate at zero
  // because the count never goes below 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8] = 4'd9;
          if (v[15:12] != 4'd0) begin
            r[15:12] = v[15:12] - 4'd1;
          end else begin
            r[15:12] = 4'd0;
          end
        end
      end
    end
    bcd_dec = r;
  endfunction

  // Next-state, next-count and borrow decode; load overrides everything.
  always_comb begin
    state_next  = state;
    s_next      = s;
    borrow_next = 1'b0;
    if (load) begin
      state_next = IDLE;
      s_next     = {clamp_tens(preset_min[7:4]), clamp_ones(preset_min[3:0]),
                    clamp_tens(preset_sec[7:4]), clamp_ones(preset_sec[3:0])};
    end else begin
      case (state)
        IDLE: begin
          if (start && (s != 16'h0000)) begin
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (tick) begin
            s_next = bcd_dec(s);
            if (s == 16'h0001) begin
              state_next  = DONE;
              borrow_next = 1'b1;
            end else begin
              state_next = RUN;
            end
          end else begin
            state_next = RUN;
          end
        end
        PAUSE: begin
          if (start) begin
            state_next = RUN;
          end else begin
            state_next = PAUSE;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, count and borrow registers with asynchronous default restore.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      s          <= {DEFAULT_MIN, DEFAULT_SEC};
      borrow_out <= 1'b0;
    end else begin
      state      <= state_next;
      s          <= s_next;
      borrow_out <= borrow_next;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

  seven_segment u_seg_sec_ones (.digit(s[3:0]),   .seg(q[6:0]));
  seven_segment u_seg_sec_tens (.digit(s[7:4]),   .seg(q[13:7]));
  seven_segment u_seg_min_ones (.digit(s[11:8]),  .seg(q[20:14]));
  seven_segment u_seg_min_tens (.digit(s[15:12]), .seg(q[27:21]));

endmodule
